// File: rtl/ioctl_upload_server.sv
// Serves HPS upload byte reads from a 16-bit toggle req/ack memory port, with a one-word
// cache so the odd byte of the last fetched word is returned without a second fetch.
module ioctl_upload_server #(
  parameter logic [7:0]  INDEX   = 8'd4,
  parameter logic [24:0] SIZE    = 25'd1024,
  parameter int unsigned AW      = 23,
  parameter logic [15:0] TIMEOUT = 16'd4095
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_q,
  output logic          err,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      din_q, din_d;
  logic            wait_q, wait_d;
  logic            req_q, req_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            sel_q, sel_d;
  logic [15:0]     cache_q, cache_d;
  logic [AW-1:0]   cache_addr_q, cache_addr_d;
  logic            cache_valid_q, cache_valid_d;
  logic            err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            upload_q;

  logic            rd_active;
  logic            upl_edge;
  logic            upl_rise;
  logic [AW-1:0]   word_addr;
  logic            out_of_range;
  logic            cache_hit;
  logic            ack_seen;
  logic            timed_out;

  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

  assign rd_active    = ioctl_rd & ioctl_upload & (ioctl_index == INDEX);
  assign upl_edge     = ioctl_upload ^ upload_q;
  assign upl_rise     = ioctl_upload & ~upload_q;
  assign word_addr    = ioctl_addr[AW:1];
  assign out_of_range = (ioctl_addr >= SIZE);
  // A cache line is stale the moment an upload starts or ends.
  assign cache_hit    = cache_valid_q & ~upl_edge & (cache_addr_q == word_addr);
  assign ack_seen     = (mem_ack == req_q);
  assign timed_out    = (cnt_q == TIMEOUT);

  // State register and datapath registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= StIdle;
      din_q         <= 8'h00;
      wait_q        <= 1'b0;
      req_q         <= 1'b0;
      addr_q        <= '0;
      sel_q         <= 1'b0;
      cache_q       <= 16'h0000;
      cache_addr_q  <= '0;
      cache_valid_q <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= 16'h0000;
      upload_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      din_q         <= din_d;
      wait_q        <= wait_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      sel_q         <= sel_d;
      cache_q       <= cache_d;
      cache_addr_q  <= cache_addr_d;
      cache_valid_q <= cache_valid_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      upload_q      <= ioctl_upload;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rd_active && !out_of_range && !cache_hit) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (ack_seen || timed_out) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    din_d         = din_q;
    wait_d        = wait_q;
    req_d         = req_q;
    addr_d        = addr_q;
    sel_d         = sel_q;
    cache_d       = cache_q;
    cache_addr_d  = cache_addr_q;
    cache_valid_d = cache_valid_q;
    err_d         = err_q;
    cnt_d         = cnt_q;

    if (upl_edge) begin
      cache_valid_d = 1'b0;
    end
    if (upl_rise) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (rd_active) begin
          if (out_of_range) begin
            din_d = 8'hFF;
          end else if (cache_hit) begin
            din_d = pick_byte(cache_q, ioctl_addr[0]);
          end else begin
            addr_d = word_addr;
            sel_d  = ioctl_addr[0];
            req_d  = ~req_q;
            wait_d = 1'b1;
            cnt_d  = 16'h0000;
          end
        end
      end
      StFetch: begin
        // Ack takes priority over a coincident timeout.
        if (ack_seen) begin
          cache_d       = mem_q;
          cache_addr_d  = addr_q;
          cache_valid_d = ~upl_edge;
          din_d         = pick_byte(mem_q, sel_q);
        end else if (timed_out) begin
          din_d         = 8'hFF;
          err_d         = 1'b1;
          cache_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: begin
        wait_d = 1'b0;
      end
      default: begin
        wait_d = 1'b0;
      end
    endcase
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign err        = err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/ioctl_upload_server.md
# ioctl_upload_server

Read-side counterpart to the ROM download path: serves HPS upload requests (`ioctl_upload` / `ioctl_rd`) by fetching 16-bit words from a backing memory port over the toggle req/ack handshake and returning the addressed byte on `ioctl_din`. It holds `ioctl_wait` while a fetch is outstanding. A one-word cache avoids refetching the odd byte of the same word. It sits in `emu` between `hps_io` and a spare SDRAM/BRAM port, and is used for NVRAM/high-score save.

## Interface
Parameters
- `INDEX`, 8'd4: `ioctl_index` value this block answers; other indices are ignored.
- `SIZE`, 25'd1024: upload image size in bytes; addresses ≥ SIZE read 8'hFF with no fetch.
- `AW`, 23: word address width driven on `mem_addr`.
- `TIMEOUT`, 16'd4095: cycles to wait for `mem_ack` before aborting the fetch.

Ports
- `clk_sys` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `ioctl_upload` in 1: upload in progress.
- `ioctl_index` in 8: selected image index.
- `ioctl_rd` in 1: one-cycle byte read strobe.
- `ioctl_addr` in 25: byte address of the read.
- `ioctl_din` out 8: returned byte.
- `ioctl_wait` out 1: byte not yet valid; HPS stalls while high.
- `mem_req` out 1: toggle request.
- `mem_addr` out AW: word address, `ioctl_addr[AW:1]`.
- `mem_ack` in 1: toggles to equal `mem_req` when `mem_q` is valid.
- `mem_q` in 16: word data; low byte = even address.
- `err` out 1: sticky; set by a timeout, cleared by reset or a new upload start.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, FETCH, DONE.
- Active read: `ioctl_rd & ioctl_upload & (ioctl_index==INDEX)`. An `ioctl_rd` in FETCH or DONE is ignored; HPS honours `ioctl_wait`.
- IDLE, active read:
  - Out of range (addr ≥ SIZE): `ioctl_din`←8'hFF, stay IDLE, `ioctl_wait` stays 0.
  - Cache hit (cache valid and cached word addr == `ioctl_addr[AW:1]`): `ioctl_din`←byte selected by `ioctl_addr[0]`, stay IDLE, no wait.
  - Miss: latch the word address and `ioctl_addr[0]`, toggle `mem_req`, set `ioctl_wait`=1, start the timeout counter, go to FETCH.
- FETCH:
  - When `mem_ack==mem_req`: latch `mem_q` into the cache, set cache valid, drive the selected byte onto `ioctl_din`, go to DONE.
  - When the counter reaches TIMEOUT: `ioctl_din`←8'hFF, set `err`, invalidate the cache, go to DONE.
  - If ack and timeout occur in the same cycle, ack wins.
- DONE: `ioctl_wait`←0, go to IDLE.
- Rising `ioctl_upload`: invalidate the cache and clear `err`.
- Falling `ioctl_upload`: invalidate the cache. An outstanding FETCH still completes normally.
- `mem_addr` is registered and holds its value from the req toggle until the next miss.
- Reset values: state IDLE, `ioctl_din`=8'h00, `ioctl_wait`=0, `mem_req`=0, `mem_addr`=0, cache invalid, `err`=0, `busy`=0. The memory side shares `reset`, so its ack also returns to 0.
- Reset mid-FETCH: abort immediately with the values above. A late ack is not consumed.

## Timing
- Hit or out-of-range: `ioctl_din` is valid 1 cycle after `ioctl_rd`; `ioctl_wait` never rises.
- Miss:
  - `mem_req` toggles and `ioctl_wait` rises 1 cycle after `ioctl_rd`.
  - If ack is first seen equal in cycle N, `ioctl_din` is valid at N+1 and `ioctl_wait` falls at N+2.
  - Minimum miss latency, rd to wait low: 3 cycles plus memory latency.
- Timeout: `ioctl_wait` falls TIMEOUT+2 cycles after `mem_req` toggles.
- Back-to-back reads: a new `ioctl_rd` is accepted in the cycle after `ioctl_wait` falls.

## Test plan
- Memory word 0 = 16'hBEEF, 4-cycle ack latency; rd addr 0 then addr 1 → `ioctl_din` 8'hEF after the fetch, then 8'hBE on a hit with no `mem_req` toggle and `ioctl_wait` never high.
- SIZE=1024, rd addr 1024 → `ioctl_din`=8'hFF one cycle later; no req toggle, no wait.
- Memory never acks, TIMEOUT=16 → wait high for 18 cycles, then `ioctl_din`=8'hFF and `err`=1; the next rising `ioctl_upload` clears `err`.
- `ioctl_index`=3 with INDEX=4, rd pulses → no response; `mem_req` and `ioctl_din` unchanged.
- Assert `reset` 2 cycles into FETCH → next cycle: wait 0, `mem_req` 0, busy 0; a following rd addr 0 performs a fresh fetch.
- Sequential read of 8 bytes (0..7) against an incrementing-word memory → exactly 4 req toggles and correct byte order.
